// File: rtl/dmem_pkg.sv
// Shared MEM-stage definitions: funct3 width codes and the store buffer entry layout.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/store_fmt.sv
// Store formatter: lane replication and byte enables for SB/SH/SW.
// DMEM_MISALIGN_TRAP_EN adds a misaligned flag and rejects misaligned SH/SW.
module store_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]   i_funct3,
  input  logic [31:0]  i_addr,
  input  logic [31:0]  i_wdata,
  output store_entry_t o_entry,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic         o_misaligned,
`endif
  output logic         o_enq_ok
);

  logic [1:0] w_a;
  logic       w_legal;
  logic       w_mis;

  assign w_a = i_addr[1:0];

  always_comb begin
    o_entry.waddr = i_addr[31:2];
    o_entry.data  = 32'd0;
    o_entry.be    = 4'b0000;
    w_legal       = 1'b0;
    w_mis         = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_entry.data = {4{i_wdata[7:0]}};
        o_entry.be   = 4'b0001 << w_a;
        w_legal      = 1'b1;
      end
      F3_H: begin
        // a[0] is ignored here; the halfword lands on its natural boundary
        o_entry.data = {2{i_wdata[15:0]}};
        o_entry.be   = 4'b0011 << {w_a[1], 1'b0};
        w_legal      = 1'b1;
        w_mis        = w_a[0];
      end
      F3_W: begin
        o_entry.data = i_wdata;
        o_entry.be   = 4'b1111;
        w_legal      = 1'b1;
        w_mis        = (w_a != 2'b00);
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign o_misaligned = w_mis;
  assign o_enq_ok     = w_legal && !w_mis;
`else
  assign o_enq_ok     = w_legal;
  logic w_unused_mis;
  assign w_unused_mis = w_mis;
`endif

endmodule

// File: rtl/dmem_store_buffer.sv
// MEM-stage store buffer: formats stores, queues them in a DEPTH-entry FIFO and drains to dmem.
// DMEM_MISALIGN_TRAP_EN enables the MisalignedM port and drops misaligned SH/SW stores.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StoreM,
  input  logic        LoadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallStoreM,
  output logic        StallLoadM,
  output logic        MemWValid,
  input  logic        MemWReady,
  output logic [31:0] MemWAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemWBE,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        MisalignedM,
`endif
  output logic        SBEmpty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  store_entry_t   r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;

  store_entry_t   w_entry;
  logic           w_enq_ok;
  logic           w_full;
  logic           w_enq;
  logic           w_deq;
  logic           w_hit;

  store_fmt u_fmt (
    .i_funct3     (funct3M),
    .i_addr       (ALUResultM),
    .i_wdata      (WriteDataM),
    .o_entry      (w_entry),
`ifdef DMEM_MISALIGN_TRAP_EN
    .o_misaligned (MisalignedM),
`endif
    .o_enq_ok     (w_enq_ok)
  );

  assign w_full      = (r_count == FULL_CNT);
  assign SBEmpty     = (r_count == '0);
  assign MemWValid   = !SBEmpty;
  // Full blocks the store even when the head drains this cycle
  assign StallStoreM = StoreM && w_enq_ok && w_full;
  assign w_enq       = StoreM && w_enq_ok && !w_full;
  assign w_deq       = MemWValid && MemWReady;

  assign MemWAddr = {r_mem[r_head].waddr, 2'b00};
  assign MemWData = r_mem[r_head].data;
  assign MemWBE   = r_mem[r_head].be;

  // A retiring entry still counts as a hit; the load goes the cycle after
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_mem[i].waddr == ALUResultM[31:2])) w_hit = 1'b1;
    end
  end

  assign StallLoadM = LoadM && w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_tail]   <= w_entry;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
